// File: rtl/wt_dcache_inv_queue_pkg.sv
// Shared types and constants for the write-through dcache invalidation path.
// The invalidation queue and its line matcher both import this package.
package wt_dcache_inv_queue_pkg;

    localparam int unsigned PLEN                   = 56;
    localparam int unsigned DCACHE_OFFSET_WIDTH    = 4;
    localparam int unsigned DCACHE_INV_QUEUE_DEPTH = 4;

    typedef logic [PLEN-DCACHE_OFFSET_WIDTH-1:0] dcache_line_addr_t;

    // Strip the byte offset so that any address inside a line maps to one key
    function automatic dcache_line_addr_t line_of(input logic [PLEN-1:0] paddr);
        return paddr[PLEN-1:DCACHE_OFFSET_WIDTH];
    endfunction

endpackage

// File: rtl/wt_dcache_inv_match.sv
// Combinational DEPTH-way comparator: hits when the incoming line equals any
// valid queue entry, except entries masked because they are popped this cycle.
module wt_dcache_inv_match
    import wt_dcache_inv_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DCACHE_INV_QUEUE_DEPTH
) (
    input  dcache_line_addr_t [DEPTH-1:0] entry_lines,
    input  logic [DEPTH-1:0]              entry_valid,
    input  logic [DEPTH-1:0]              pop_mask,
    input  dcache_line_addr_t             line,
    output logic                          hit
);

    // OR-reduce the per-entry matches
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit = hit | (entry_valid[i] & ~pop_mask[i] & (entry_lines[i] == line));
        end
    end

endmodule

// File: rtl/wt_dcache_inv_queue_checker.sv
// Protocol and occupancy properties for the invalidation queue.
// Concurrent assertions only; no logic drives anything from here.
module wt_dcache_inv_queue_checker
    import wt_dcache_inv_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DCACHE_INV_QUEUE_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic             push,
    input logic             full,
    input logic             req,
    input logic             ack,
    input logic [PLEN-1:0]  paddr,
    input logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full));

    a_paddr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req && !ack) |=> $stable(paddr));

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= MAX_CNT);

endmodule

// File: rtl/wt_dcache_inv_queue.sv
// Invalidation queue between the NoC adapter and the dcache invalidation unit:
// line-aligns, optionally coalesces duplicate lines, and hands them out in FIFO order.
module wt_dcache_inv_queue
    import wt_dcache_inv_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = DCACHE_INV_QUEUE_DEPTH,
    parameter bit          COALESCE = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            bus_inv_valid_i,
    input  logic [PLEN-1:0] bus_inv_paddr_i,
    output logic            bus_inv_ready_o,
    output logic            mem_inv_req_o,
    output logic [PLEN-1:0] mem_inv_paddr_o,
    input  logic            mem_inv_ack_i,
    output logic            inv_pending_o,
    output logic            inv_dropped_o
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    dcache_line_addr_t [DEPTH-1:0] lines_r;
    logic [DEPTH-1:0]              valid_r;
    logic [PTR_W-1:0]              rd_ptr_r;
    logic [PTR_W-1:0]              wr_ptr_r;
    logic [CNT_W-1:0]              count_r;
    logic                          req_r;

    logic [CNT_W-1:0]  count_next_s;
    logic [DEPTH-1:0]  pop_mask_s;
    dcache_line_addr_t line_in_s;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              hit_s;
    logic              drop_s;
    logic              store_s;
    logic              unused_offset_s;

    assign line_in_s       = line_of(bus_inv_paddr_i);
    assign unused_offset_s = ^bus_inv_paddr_i[DCACHE_OFFSET_WIDTH-1:0];

    assign full_s  = (count_r == FULL_CNT);
    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign push_s  = bus_inv_valid_i & ~full_s;
    assign pop_s   = mem_inv_ack_i & ~empty_s;

    // The head leaving this cycle must not absorb a new push of the same line
    always_comb begin
        pop_mask_s = {DEPTH{1'b0}};
        if (pop_s) begin
            pop_mask_s[rd_ptr_r] = 1'b1;
        end else begin
            pop_mask_s = {DEPTH{1'b0}};
        end
    end

    wt_dcache_inv_match #(
        .DEPTH (DEPTH)
    ) i_match (
        .entry_lines (lines_r),
        .entry_valid (valid_r),
        .pop_mask    (pop_mask_s),
        .line        (line_in_s),
        .hit         (hit_s)
    );

    // Decide whether an accepted message is stored or discarded
    always_comb begin
        drop_s = 1'b0;
        if ((COALESCE == 1'b1) && push_s && hit_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
        store_s = push_s & ~drop_s;
    end

    // Occupancy after this cycle's store and pop
    always_comb begin
        count_next_s = count_r;
        case ({store_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Queue storage, pointers and the registered request flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lines_r  <= {DEPTH{{(PLEN-DCACHE_OFFSET_WIDTH){1'b0}}}};
            valid_r  <= {DEPTH{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            req_r    <= 1'b0;
        end else begin
            if (store_s) begin
                lines_r[wr_ptr_r] <= line_in_s;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + PTR_ONE;
            end
            // store and pop never hit the same slot: that needs full or empty
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            req_r   <= (count_next_s != {CNT_W{1'b0}});
        end
    end

    assign bus_inv_ready_o = ~full_s;
    assign mem_inv_req_o   = req_r;
    assign inv_pending_o   = req_r;
    assign inv_dropped_o   = drop_s;
    assign mem_inv_paddr_o = req_r ? {lines_r[rd_ptr_r], {DCACHE_OFFSET_WIDTH{1'b0}}}
                                   : {PLEN{1'b0}};

    wt_dcache_inv_queue_checker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) i_checker (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push_s),
        .full   (full_s),
        .req    (req_r),
        .ack    (mem_inv_ack_i),
        .paddr  (mem_inv_paddr_o),
        .count  (count_r)
    );

endmodule
